// File: rtl/memory_chain_reader.sv
// rtl/memory_chain_reader.sv - walks a footer-linked chain of SRAM blocks and streams them out
// One read outstanding at a time; a read is only issued when the FIFO has room for its data.
module memory_chain_reader #(
  parameter int ADDR_W     = 12,
  parameter int BLOCK_BITS = 128,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BLOCKS = 64,
  localparam int CNT_W     = $clog2(MAX_BLOCKS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     start_addr_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  mem_re_o,
  output logic [ADDR_W-1:0]     mem_raddr_o,
  input  logic                  mem_rvalid_i,
  input  logic [BLOCK_BITS-1:0] mem_rdata_i,
  output logic [BLOCK_BITS-1:0] data_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic                  data_end_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [CNT_W-1:0]      blk_cnt_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(MAX_BLOCKS);
  // A zero-latency memory cannot be served by this handshake, so never issue.
  localparam bit LAT_OK = (RD_LAT >= 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_FLUSH} state_t;

  state_t                state, state_next;
  logic [ADDR_W-1:0]     cur_addr, raddr_q;
  logic [BLOCK_BITS-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_end;
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [PTR_W:0]        count;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  issue, push, pop, flush, start_ok;
  logic                  eop, at_limit, rd_end;

  assign eop      = mem_rdata_i[3];
  assign cnt_inc  = blk_cnt_o + 1'b1;
  assign at_limit = (cnt_inc == LIMIT);
  assign rd_end   = eop | at_limit;

  assign busy_o       = (state != S_IDLE);
  assign data_valid_o = (count != '0);
  assign data_o       = fifo_data[rd_ptr];
  assign data_end_o   = data_valid_o & fifo_end[rd_ptr];
  assign pop          = data_valid_o & data_ready_i;
  assign mem_re_o     = issue;
  assign mem_raddr_o  = issue ? cur_addr : raddr_q;

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    push       = 1'b0;
    done_o     = 1'b0;
    start_ok   = 1'b0;
    flush      = abort_i && (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          start_ok   = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort_i) begin
          state_next = S_IDLE;
        end else if (LAT_OK && (count < FULL_CNT)) begin
          issue      = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // A read still in flight at abort must be swallowed before going idle.
        if (abort_i) begin
          state_next = mem_rvalid_i ? S_IDLE : S_FLUSH;
        end else if (mem_rvalid_i) begin
          push       = 1'b1;
          state_next = rd_end ? S_DRAIN : S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (abort_i) begin
          state_next = S_IDLE;
        end else if (count == '0) begin
          done_o     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (mem_rvalid_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      raddr_q   <= '0;
      blk_cnt_o <= '0;
      err_o     <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fifo_end  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data[i] <= '0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        cur_addr  <= start_addr_i;
        blk_cnt_o <= '0;
        err_o     <= 1'b0;
      end
      if (issue) raddr_q <= cur_addr;
      if (push) begin
        blk_cnt_o <= cnt_inc;
        if (at_limit && !eop) err_o <= 1'b1;
        if (!rd_end) cur_addr <= mem_rdata_i[4 +: ADDR_W];
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          fifo_data[wr_ptr] <= mem_rdata_i;
          fifo_end[wr_ptr]  <= rd_end;
          wr_ptr            <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_chain_reader.sv
// tb/tb_memory_chain_reader.sv - directed bench with a chain-walking reference model
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_memory_chain_reader;

  localparam int ADDR_W = 12, BLOCK_BITS = 128, FIFO_DEPTH = 4, MAX_BLOCKS = 64;
  localparam int CNT_W = $clog2(MAX_BLOCKS + 1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start_i = 1'b0;
  logic [ADDR_W-1:0]     start_addr_i = '0;
  logic                  abort_i = 1'b0;
  logic                  busy_o, mem_re_o, data_valid_o, data_end_o, done_o, err_o;
  logic [ADDR_W-1:0]     mem_raddr_o;
  logic                  mem_rvalid_i = 1'b0;
  logic [BLOCK_BITS-1:0] mem_rdata_i = '0;
  logic [BLOCK_BITS-1:0] data_o;
  logic                  data_ready_i = 1'b0;
  logic [CNT_W-1:0]      blk_cnt_o;

  memory_chain_reader #(
    .ADDR_W(ADDR_W), .BLOCK_BITS(BLOCK_BITS), .RD_LAT(1),
    .FIFO_DEPTH(FIFO_DEPTH), .MAX_BLOCKS(MAX_BLOCKS)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .start_addr_i(start_addr_i),
    .abort_i(abort_i), .busy_o(busy_o), .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .data_o(data_o),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_end_o(data_end_o),
    .done_o(done_o), .err_o(err_o), .blk_cnt_o(blk_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Block image: tag in the payload, footer {next_idx, eop, rsvd}.
  logic [127:0] mem [4096];
  function automatic logic [127:0] mk_block(input int idx, input int nxt, input bit eop);
    logic [15:0] tag;
    tag = 16'(idx) ^ 16'hA5C3;
    return {{7{tag}}, 12'(nxt), eop, 3'b101};
  endfunction

  // Reference: walk the memory image the way the chain is defined.
  logic [127:0] exp_data_q[$];
  logic         exp_end_q[$];
  logic [11:0]  exp_addr_q[$];
  int           exp_total = 0;
  logic         exp_err = 1'b0;

  task automatic build_model(input logic [11:0] start);
    logic [11:0] a;
    int n;
    a = start;
    n = 0;
    exp_data_q.delete(); exp_end_q.delete(); exp_addr_q.delete();
    while (1) begin
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem[a]);
      n++;
      if (mem[a][3] || n == MAX_BLOCKS) begin
        exp_end_q.push_back(1'b1);
        break;
      end
      exp_end_q.push_back(1'b0);
      a = mem[a][15:4];
    end
    exp_total = n;
    exp_err   = !mem[a][3];
  endtask

  task automatic clear_model();
    exp_data_q.delete(); exp_end_q.delete(); exp_addr_q.delete();
  endtask

  // Memory: answers each read strobe mem_lat cycles later.
  int          mem_lat = 1;
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [11:0] pend_addr = '0;
  always @(negedge clk) begin
    mem_rvalid_i = 1'b0;
    if (rst) begin
      pend = 0;
    end else begin
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mem[pend_addr];
          pend = 0;
        end
      end
      if (mem_re_o) begin
        pend      = 1;
        pend_cnt  = mem_lat;
        pend_addr = mem_raddr_o;
      end
    end
  end

  int re_count = 0, beats = 0, dones = 0;
  int last_re = -1, last_pop = -10;
  bit period_chk = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_re_o) begin
        re_count++;
        chk("re_expected", exp_addr_q.size() > 0, 1'b1);
        if (exp_addr_q.size() > 0) chk("raddr", mem_raddr_o, exp_addr_q.pop_front());
        if (period_chk && last_re >= 0) chk("re_period", cyc - last_re, mem_lat + 1);
        last_re = cyc;
      end
      if (data_valid_o && data_ready_i) begin
        chk("beat_expected", exp_data_q.size() > 0, 1'b1);
        if (exp_data_q.size() > 0) begin
          chk("beat_data", data_o, exp_data_q.pop_front());
          chk("beat_end", data_end_o, exp_end_q.pop_front());
        end
        beats++;
        last_pop = cyc;
      end
      if (done_o) begin
        dones++;
        chk("done_after_pop", cyc, last_pop + 1);
        chk("done_beats_left", exp_data_q.size(), 0);
        chk("done_blk_cnt", blk_cnt_o, exp_total);
        chk("done_err", err_o, exp_err);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_chain(input logic [11:0] a);
    build_model(a);
    last_re      = -1;
    start_i      = 1'b1;
    start_addr_i = a;
    tick();
    start_i      = 1'b0;
    start_addr_i = '0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0, k;
    d0 = dones;
    k  = 0;
    while (dones == d0 && k < budget) begin
      tick();
      k++;
    end
    chk(name, dones != d0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_re"}, mem_re_o, 0);
    chk({tag, "_raddr"}, mem_raddr_o, 0);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_valid"}, data_valid_o, 0);
    chk({tag, "_end"}, data_end_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_cnt"}, blk_cnt_o, 0);
  endtask

  int chain1 [10] = '{37, 905, 128, 2047, 319, 4093, 777, 2560, 1234, 3001};

  initial begin
    int b0, d0, k, cnt_abort;
    for (int i = 0; i < 4096; i++) mem[i] = mk_block(i, 0, 1'b1);
    for (int i = 0; i < 9; i++) mem[chain1[i]] = mk_block(chain1[i], chain1[i+1], 1'b0);
    mem[3001] = mk_block(3001, 0, 1'b1);

    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // 1: ten-block chain, consumer always ready
    mem_lat = 1; data_ready_i = 1'b1; period_chk = 1;
    re_count = 0; b0 = beats; d0 = dones;
    start_chain(12'd37);
    chk("t1_model_len", exp_total, 10);
    wait_done("t1_done", 200);
    chk("t1_re_count", re_count, 10);
    chk("t1_beats", beats - b0, 10);
    chk("t1_dones", dones - d0, 1);
    chk("t1_blk_cnt", blk_cnt_o, 10);
    chk("t1_err", err_o, 0);
    chk("t1_idle", busy_o, 0);

    // 2: consumer stalls; issue throttles at FIFO_DEPTH reads
    data_ready_i = 1'b0; period_chk = 0;
    re_count = 0; b0 = beats;
    start_chain(12'd37);
    tick(30);
    chk("t2_stalled_reads", re_count, 4);
    chk("t2_valid", data_valid_o, 1);
    data_ready_i = 1'b1;
    wait_done("t2_done", 200);
    chk("t2_beats", beats - b0, 10);
    chk("t2_re_count", re_count, 10);

    // 3: self-loop without eop is cut at MAX_BLOCKS
    mem[3001] = mk_block(3001, 3001, 1'b0);
    period_chk = 1; b0 = beats; d0 = dones;
    start_chain(12'd3001);
    chk("t3_model_len", exp_total, 64);
    wait_done("t3_done", 400);
    chk("t3_beats", beats - b0, 64);
    chk("t3_dones", dones - d0, 1);
    chk("t3_err", err_o, 1);
    tick(5);
    chk("t3_err_sticky", err_o, 1);
    chk("t3_blk_cnt", blk_cnt_o, 64);
    mem[3001] = mk_block(3001, 0, 1'b1);

    // 4: single block at index 0
    mem[0] = mk_block(0, 0, 1'b1);
    b0 = beats;
    start_chain(12'd0);
    chk("t4_model_len", exp_total, 1);
    chk("t4_err_cleared", err_o, 0);
    chk("t4_busy", busy_o, 1);
    wait_done("t4_done", 50);
    chk("t4_beats", beats - b0, 1);

    // 5: abort while a 3-cycle read is outstanding
    mem_lat = 3; re_count = 0; d0 = dones;
    start_chain(12'd37);
    k = 0;
    while (re_count < 3 && k < 100) begin
      tick();
      k++;
    end
    chk("t5_reach_third_read", re_count >= 3, 1'b1);
    cnt_abort = blk_cnt_o;
    chk("t5_cnt_before_abort", cnt_abort, 2);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    clear_model();
    chk("t5_flushed_valid", data_valid_o, 0);
    k = 0;
    while (busy_o && k < 20) begin
      tick();
      k++;
    end
    chk("t5_flush_len", k, 2);
    chk("t5_idle", busy_o, 0);
    chk("t5_discarded", blk_cnt_o, 2);
    chk("t5_no_done", dones - d0, 0);
    chk("t5_valid_after", data_valid_o, 0);
    b0 = beats;
    start_chain(12'd37);
    wait_done("t5_restart_done", 300);
    chk("t5_restart_beats", beats - b0, 10);
    chk("t5_restart_cnt", blk_cnt_o, 10);

    // 6: reset mid-chain, then walk from a new start address
    mem_lat = 1; re_count = 0;
    start_chain(12'd37);
    k = 0;
    while (re_count < 5 && k < 100) begin
      tick();
      k++;
    end
    chk("t6_reach_fifth_read", re_count >= 5, 1'b1);
    rst = 1'b1;
    tick();
    check_all_zero("t6_reset");
    rst = 1'b0;
    clear_model();
    tick(4);
    b0 = beats;
    start_chain(12'd2047);
    chk("t6_model_len", exp_total, 7);
    wait_done("t6_done", 200);
    chk("t6_beats", beats - b0, 7);
    chk("t6_blk_cnt", blk_cnt_o, 7);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
